// File: rtl/barcode_rdr_param.sv
// Barcode frame reader: synchronised, glitch-filtered line; a start bit calibrates
// the bit period, then ID_W data bits are sampled one period after each falling edge.
module barcode_rdr_param #(
  parameter int ID_W     = 8,
  parameter int FILT_N   = 3,
  parameter int TMR_W    = 22,
  parameter int TO_SHIFT = 1,
  parameter int CHK_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            BC,
  input  logic            clr_ID_vld,
  input  logic            clr_err,
  output logic [ID_W-1:0] ID,
  output logic            ID_vld,
  output logic            err,
  output logic [1:0]      err_code
);

  localparam int CNT_W = $clog2(ID_W + 1);
  localparam int LIM_W = TMR_W + TO_SHIFT;
  localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAL   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_COUNT = 2'd3
  } state_t;

  state_t            state_r;
  logic              bc_meta_r;
  logic              bc_sync_r;
  logic [FILT_N-2:0] hist_r;
  logic [FILT_N-1:0] win_s;
  logic              filt_r;
  logic              filt_d_r;
  logic              rise_s;
  logic              fall_s;
  logic [TMR_W-1:0]  timer_r;
  logic [TMR_W-1:0]  time_prd_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [LIM_W-1:0]  lim_s;
  logic [ID_W-1:0]   word_nxt_s;
  logic              chk_ok_s;

  function automatic logic chk_pass(input logic [ID_W-1:0] w);
    logic ok;
    case (CHK_MODE)
      0:       ok = (w[ID_W-1:ID_W-2] == 2'b00);
      1:       ok = ~(^w);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Sample window, edge pulses, timeout limit and the word as it would be after a shift
  always_comb begin
    win_s      = {hist_r, bc_sync_r};
    rise_s     = filt_r & ~filt_d_r;
    fall_s     = ~filt_r & filt_d_r;
    lim_s      = LIM_W'(time_prd_r) << TO_SHIFT;
    word_nxt_s = {ID[ID_W-2:0], filt_r};
    chk_ok_s   = chk_pass(word_nxt_s);
  end

  // Synchroniser, sample history and hysteretic filtered line
  always_ff @(posedge clk) begin
    if (rst) begin
      bc_meta_r <= 1'b1;
      bc_sync_r <= 1'b1;
      hist_r    <= {(FILT_N-1){1'b1}};
      filt_r    <= 1'b1;
      filt_d_r  <= 1'b1;
    end else begin
      bc_meta_r <= BC;
      bc_sync_r <= bc_meta_r;
      hist_r    <= win_s[FILT_N-2:0];
      if (&win_s) begin
        filt_r <= 1'b1;
      end else if (~|win_s) begin
        filt_r <= 1'b0;
      end else begin
        filt_r <= filt_r;
      end
      filt_d_r <= filt_r;
    end
  end

  // Frame FSM; error/valid sets sit after the clears so a set wins the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      timer_r    <= '0;
      time_prd_r <= '0;
      bit_cnt_r  <= '0;
      ID         <= '0;
      ID_vld     <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      if (clr_ID_vld) ID_vld <= 1'b0;
      if (clr_err) begin
        err      <= 1'b0;
        err_code <= 2'b00;
      end
      case (state_r)
        ST_IDLE: begin
          if (fall_s) begin
            timer_r   <= '0;
            bit_cnt_r <= '0;
            ID_vld    <= 1'b0;
            state_r   <= ST_CAL;
          end
        end
        ST_CAL: begin
          if (rise_s) begin
            time_prd_r <= timer_r;
            timer_r    <= '0;
            state_r    <= ST_WAIT;
          end else if (timer_r == TMR_MAX) begin
            err      <= 1'b1;
            err_code <= 2'b11;
            state_r  <= ST_IDLE;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        ST_WAIT: begin
          if (fall_s) begin
            timer_r <= '0;
            state_r <= ST_COUNT;
          end else if (LIM_W'(timer_r) == lim_s) begin
            err      <= 1'b1;
            err_code <= 2'b01;
            state_r  <= ST_IDLE;
          end else if (timer_r != TMR_MAX) begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        ST_COUNT: begin
          if (timer_r == time_prd_r) begin
            ID        <= word_nxt_s;
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            if (bit_cnt_r == CNT_W'(ID_W - 1)) begin
              state_r <= ST_IDLE;
              if (chk_ok_s) begin
                ID_vld <= 1'b1;
              end else begin
                err      <= 1'b1;
                err_code <= 2'b10;
              end
            end else begin
              timer_r <= '0;
              state_r <= ST_WAIT;
            end
          end else if (timer_r != TMR_MAX) begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/barcode_rdr_param.md
BARCODE_RDR_PARAM -- requirements
Module: barcode_rdr_param

Interface
REQ-001 Parameter ID_W, default 8: number of data bits per barcode frame, MSB first; legal range 2..16.
REQ-002 Parameter FILT_N, default 3: consecutive equal raw samples required before the filtered line changes; legal range 2..8.
REQ-003 Parameter TMR_W, default 22: width of the period/timer counters.
REQ-004 Parameter TO_SHIFT, default 1: timeout limit = time_prd << TO_SHIFT.
REQ-005 Parameter CHK_MODE, default 0: 0 = two MSBs must be 0; 1 = even parity over all ID_W bits; 2 = no check.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 BC  input  1  raw barcode line, asynchronous to clk, idle high.
REQ-009 clr_ID_vld  input  1  one-cycle strobe clearing ID_vld.
REQ-010 clr_err  input  1  one-cycle strobe clearing err and err_code.
REQ-011 ID  output  ID_W  shift register contents, most recent bit in LSB.
REQ-012 ID_vld  output  1  complete frame received and check passed.
REQ-013 err  output  1  sticky frame-error flag.
REQ-014 err_code  output  2  01 timeout, 10 check fail, 11 calibration overflow, 00 none.

Function
REQ-015 BC SHALL pass through a two-flop synchroniser, then a FILT_N-deep history; filtered line goes 1 only when all FILT_N samples are 1 and goes 0 only when all are 0; otherwise it holds.
REQ-016 Rising/falling edges SHALL be detected from the filtered line and one delayed copy; edge pulses last one cycle.
REQ-017 FSM states SHALL be IDLE, CAL, WAIT, COUNT.
REQ-018 IDLE: on falling edge, clear timer, bit counter and ID_vld, then go to CAL; otherwise stay.
REQ-019 CAL: increment timer each cycle; on rising edge, latch time_prd = timer, clear timer, go to WAIT.
REQ-020 CAL: if timer reaches all-ones before a rising edge, set err with code 11 and go to IDLE.
REQ-021 WAIT: on falling edge, clear timer and go to COUNT.
REQ-022 WAIT: else if timer equals timeout limit, set err with code 01 and go to IDLE.
REQ-023 WAIT: else increment timer.
REQ-024 COUNT: when timer equals time_prd, shift the filtered line into the ID LSB and increment the bit counter.
REQ-025 COUNT, after that sample: if the sample was not bit ID_W, clear timer and go to WAIT.
REQ-026 COUNT, after that sample: if it was bit ID_W, evaluate CHK_MODE on the completed word (including this bit) and go to IDLE.
REQ-027 On pass, set ID_vld next cycle; on fail, set err with code 10 and leave ID_vld 0.
REQ-028 COUNT: otherwise increment timer.
REQ-029 Timeout limit SHALL be computed at TMR_W+TO_SHIFT bits with no truncation.
REQ-030 A timer at all-ones SHALL saturate (never wrap) in every state.
REQ-031 Bit counter SHALL be $clog2(ID_W+1) bits wide.
REQ-032 ID_vld priority: frame-pass set > clr_ID_vld / IDLE falling-edge clear.
REQ-033 err priority: new error set > clr_err; a later error overwrites err_code.
REQ-034 A new frame (IDLE falling edge) SHALL NOT clear err.
REQ-035 ID SHALL hold its value in IDLE until the next sample shift.
REQ-036 Detection latency: filtered edge visible 2+FILT_N cycles after a BC transition.

Reset
REQ-037 On rst: state IDLE, ID=0, ID_vld=0, err=0, err_code=00, timer=0, bit counter=0.
REQ-038 On rst: synchroniser, history and filtered line all 1.
REQ-039 rst mid-frame SHALL abort the frame without flagging an error.

Verification
REQ-040 Defaults, start-bit low for 20 clk, data bits of 40 clk (low 20 = 0 / low 10 = 1), ID 0x15 -> ID=0x15, ID_vld=1, err=0.
REQ-041 Same timing, ID 0xC5 with CHK_MODE=0 -> ID_vld=0, err=1, err_code=10; clr_err clears both.
REQ-042 Stop BC high after 3 bits with period 20 -> err_code=01 within 40 clk of the last falling edge; state IDLE.
REQ-043 One- and two-cycle BC glitches (FILT_N=3) during a frame -> no edge detected, ID unchanged from the clean run.
REQ-044 ID_vld set and clr_ID_vld asserted in the same cycle -> ID_vld=1; TMR_W=6 with start low for 100 clk -> err_code=11.
REQ-045 ID_W=12, CHK_MODE=1, word 0xA53 (even parity) -> ID_vld=1; rst pulsed at bit 5 of a frame -> all outputs zero, next frame decodes correctly.
